// File: rtl/mean_calculator.sv
// Accumulates N_SAMPLES signed X/Y samples, then divides each sum by N_SAMPLES with a restoring divider.
// Optional MEAN_CALCULATOR_ROUND_EN: round half away from zero instead of truncating toward zero.
module mean_calculator #(
  parameter int DATA_W    = 20,
  parameter int N_SAMPLES = 150,
  parameter int CNT_W     = 8,
  parameter int ACC_W     = DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dataValid,
  input  logic [DATA_W-1:0] xIn,
  input  logic [DATA_W-1:0] yIn,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] xMean,
  output logic [DATA_W-1:0] yMean
);

  localparam int BIT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ACC_W - 1);
  localparam logic [CNT_W:0]   DIVISOR  = (CNT_W + 1)'(N_SAMPLES);

  typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;

  state_t            state_q, state_nx;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIT_W-1:0]  bit_q;
  logic              take;
  logic              last;
  logic              bit_last;

  assign take     = (state_q == ACC) && dataValid;
  assign last     = take && (cnt_q == CNT_LAST);
  assign bit_last = (state_q == DIV) && (bit_q == BIT_LAST);

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (start)    state_nx = ACC;
      ACC:     if (last)     state_nx = DIV;
      DIV:     if (bit_last) state_nx = DONE;
      DONE:                  state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      bit_q <= '0;
    end else begin
      if ((state_q == IDLE) && start) begin
        cnt_q <= '0;
      end else if (take) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (last) begin
        bit_q <= '0;
      end else if (state_q == DIV) begin
        bit_q <= bit_q + BIT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_axis
    logic [DATA_W-1:0] din;
    logic [ACC_W-1:0]  acc_q, acc_nx, mag_nx;
    logic [ACC_W-1:0]  quo_q, quo_nx, mag_fin;
    logic [CNT_W-1:0]  rem_q, rem_nx;
    logic [CNT_W:0]    trial;
    logic              fits;
    logic              neg_q;
    logic [DATA_W-1:0] mean_q, mean_nx;

    assign din = (i == 0) ? xIn : yIn;

    always_comb begin
      acc_nx = acc_q + {{CNT_W{din[DATA_W-1]}}, din};
      mag_nx = acc_nx[ACC_W-1] ? (~acc_nx + ACC_W'(1)) : acc_nx;
      // Remainder stays below N_SAMPLES, so CNT_W bits hold it and trial needs one more.
      trial  = {rem_q, quo_q[ACC_W-1]};
      fits   = (trial >= DIVISOR);
      rem_nx = fits ? CNT_W'(trial - DIVISOR) : trial[CNT_W-1:0];
      quo_nx = {quo_q[ACC_W-2:0], fits};
      mag_fin = quo_nx;
`ifdef MEAN_CALCULATOR_ROUND_EN
      if ({rem_nx, 1'b0} >= DIVISOR) begin
        mag_fin = quo_nx + ACC_W'(1);
      end
`endif
      mean_nx = neg_q ? DATA_W'(~mag_fin + ACC_W'(1)) : DATA_W'(mag_fin);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_q  <= '0;
        quo_q  <= '0;
        rem_q  <= '0;
        neg_q  <= 1'b0;
        mean_q <= '0;
      end else begin
        if ((state_q == IDLE) && start) begin
          acc_q <= '0;
        end else if (take) begin
          acc_q <= acc_nx;
          // Divider is loaded on the same edge that accepts the final sample.
          if (last) begin
            quo_q <= mag_nx;
            rem_q <= '0;
            neg_q <= acc_nx[ACC_W-1];
          end
        end else if (state_q == DIV) begin
          quo_q <= quo_nx;
          rem_q <= rem_nx;
          if (bit_last) begin
            mean_q <= mean_nx;
          end
        end
      end
    end

    if (i == 0) begin : g_x
      assign xMean = mean_q;
    end else begin : g_y
      assign yMean = mean_q;
    end
  end

endmodule

// File: tb/tb_mean_calculator.sv
// Directed bench for mean_calculator with N_SAMPLES=4; expected means queued at stimulus time.
module tb_mean_calculator;

  localparam int DW = 20;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int AW = DW + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          dataValid = 1'b0;
  logic [DW-1:0] xIn = '0;
  logic [DW-1:0] yIn = '0;
  logic          ready;
  logic          done;
  logic [DW-1:0] xMean;
  logic [DW-1:0] yMean;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int last_x = 0;
  int last_y = 0;

  mean_calculator #(
    .DATA_W(DW),
    .N_SAMPLES(N),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dataValid(dataValid),
    .xIn(xIn),
    .yIn(yIn),
    .ready(ready),
    .done(done),
    .xMean(xMean),
    .yMean(yMean)
  );

  always #5 clk = ~clk;

  function automatic int mean_of(input int v[4]);
    longint sum, mag, q;
    sum = 0;
    for (int k = 0; k < 4; k++) sum += v[k];
    mag = (sum < 0) ? -sum : sum;
    q = mag / N;
`ifdef MEAN_CALCULATOR_ROUND_EN
    if (2 * (mag % N) >= N) q++;
`endif
    return int'((sum < 0) ? -q : q);
  endfunction

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, longint'(ready), 1);
  endtask

  task automatic run(input string tag, input int xs[4], input int ys[4],
                     input int gap, input bit extra_start, input bit idle_junk);
    int n, ex, ey;
    wait_ready(tag);
    if (idle_junk) begin
      dataValid = 1'b1;
      xIn = DW'(100000);
      yIn = DW'(-100000);
      repeat (3) @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dataValid = 1'b0;
    exp_q.push_back(mean_of(xs));
    exp_q.push_back(mean_of(ys));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (gap) @(negedge clk);
      dataValid = 1'b1;
      xIn = DW'(xs[k]);
      yIn = DW'(ys[k]);
      if (extra_start && k == 2) start = 1'b1;
      @(negedge clk);
      dataValid = 1'b0;
      start = 1'b0;
      if (k == 1) begin
        check({tag, "_busy"}, longint'(ready), 0);
        check({tag, "_hold_x"}, longint'($signed(xMean)), last_x);
      end
    end
    n = 1;
    while (!done && n < AW + 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, AW + 1);
    ex = exp_q.pop_front();
    ey = exp_q.pop_front();
    check({tag, "_xmean"}, longint'($signed(xMean)), ex);
    check({tag, "_ymean"}, longint'($signed(yMean)), ey);
    last_x = ex;
    last_y = ey;
    @(negedge clk);
    check({tag, "_done_pulse"}, longint'(done), 0);
    check({tag, "_ready_back"}, longint'(ready), 1);
    check({tag, "_xhold"}, longint'($signed(xMean)), ex);
  endtask

  initial begin
    int xs[4], ys[4];
    repeat (2) @(negedge clk);
    check("rst_ready", longint'(ready), 1);
    check("rst_done", longint'(done), 0);
    check("rst_xmean", longint'($signed(xMean)), 0);
    check("rst_ymean", longint'($signed(yMean)), 0);
    rst = 1'b0;
    @(negedge clk);

    xs = '{10, 10, 10, 10};  ys = '{-3, -3, -3, -3};
    run("cont", xs, ys, 0, 1'b0, 1'b0);

    xs = '{1, 2, 2, 2};  ys = '{-1, -2, -2, -2};
    run("round", xs, ys, 0, 1'b0, 1'b0);

    xs = '{524287, 524287, 524287, 524287};
    ys = '{-524288, -524288, -524288, -524288};
    run("extreme", xs, ys, 0, 1'b0, 1'b0);

    xs = '{10, 10, 10, 10};  ys = '{-3, -3, -3, -3};
    run("gapped", xs, ys, 1, 1'b1, 1'b0);

    // Abort a run after two samples with an asynchronous reset pulse.
    wait_ready("abort");
    xs = '{524287, 524287, 524287, 524287};
    run("pre_abort", xs, xs, 0, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dataValid = 1'b1;
    xIn = DW'(7);
    yIn = DW'(7);
    repeat (2) @(negedge clk);
    dataValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_ready", longint'(ready), 1);
    check("abort_done", longint'(done), 0);
    check("abort_xmean", longint'($signed(xMean)), 0);
    check("abort_ymean", longint'($signed(yMean)), 0);
    @(negedge clk);
    rst = 1'b0;
    last_x = 0;
    last_y = 0;
    @(negedge clk);

    xs = '{5, 5, 5, 5};  ys = '{5, 5, 5, 5};
    run("fresh", xs, ys, 0, 1'b0, 1'b0);

    xs = '{4, 8, -12, 20};  ys = '{3, 3, 3, 4};
    run("idle_junk", xs, ys, 2, 1'b0, 1'b1);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mean_calculator.md
Name: mean_calculator

Overview:
- Regression datapath stage directly downstream of the data-loader controller.
- Consumes the X/Y sample stream the loader replays from memory after its mean-start request.
- Accumulates N signed samples per axis, then divides each sum by N with a sequential shift-subtract divider.
- Returns xMean/yMean to the loader and to the coefficient-calculation unit.

Parameters:
DATA_W, 20, width of signed two's-complement X/Y samples and of the mean outputs
N_SAMPLES, 150, number of samples per run (>=2)
CNT_W, 8, sample counter width; must satisfy 2^CNT_W > N_SAMPLES
ACC_W, DATA_W+CNT_W, accumulator width; guarantees no overflow

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  run request (driven by the loader's meanStart); accepted only when ready=1
dataValid  in  1  xIn/yIn carry a sample this cycle
xIn  in  DATA_W  signed X sample
yIn  in  DATA_W  signed Y sample
ready  out  1  high only in IDLE; drives the loader's meanReady
done  out  1  one-cycle pulse; means valid
xMean  out  DATA_W  signed mean of X
yMean  out  DATA_W  signed mean of Y

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, ready=1, done=0, xMean=0, yMean=0; accumulators, counter and divider registers all 0.
- FSM states: IDLE, ACC, DIV, DONE.
- IDLE:
  - ready=1.
  - start=1 -> clear accumulators and counter, go to ACC.
  - dataValid in IDLE is ignored.
- ACC:
  - ready=0.
  - Each cycle with dataValid=1: xAcc+=sign-extended xIn, yAcc+=sign-extended yIn, cnt+=1.
  - The edge that accepts sample N_SAMPLES moves to DIV.
  - Cycles with dataValid=0 hold all state; gaps of any length are legal.
- DIV:
  - Load each divider with |acc|, remember each sign, divisor = N_SAMPLES.
  - Restoring division, one quotient bit per cycle per axis; X and Y run in parallel.
  - Exactly ACC_W cycles, counted by an internal bit counter, then go to DONE.
- DONE, one cycle:
  - xMean/yMean = signed quotient (negated if the sum was negative), truncated to DATA_W; the result always fits.
  - Rounding is toward zero unless ROUND_EN.
  - done=1; next state IDLE.
- Latency: last sample edge -> done high ACC_W+1 cycles later.
- xMean/yMean hold their values until the next DONE; a new start does not clear them.
- start while not in IDLE is ignored; no queuing.
- dataValid outside ACC is ignored.
- start and dataValid high in the same IDLE cycle: only start is taken; that sample is not counted.
- Reset asserted mid-run: immediate return to reset values; the partial run is discarded.

Optional Feature:
- Macro: MEAN_CALCULATOR_ROUND_EN.
- Defined: divider keeps its final remainder R. If 2R >= N_SAMPLES, magnitude is incremented before the sign is applied (round half away from zero).
- Undefined: plain truncation toward zero. No rounding logic is synthesised.

Test Plan:
- N_SAMPLES=4, samples x=10,y=-3 x4, continuous dataValid -> done exactly ACC_W+1 cycles after 4th sample; xMean=10, yMean=-3; ready returns 1 next cycle.
- N_SAMPLES=4, x=1,2,2,2 (sum 7), y=-1,-2,-2,-2 (sum -7) -> without ROUND_EN xMean=1, yMean=-1; with ROUND_EN xMean=2, yMean=-2.
- N_SAMPLES=4, x=2^(DATA_W-1)-1 and y=-2^(DATA_W-1) for all samples -> exact extremes returned; no overflow.
- dataValid toggling every other cycle (loader SendXY/Wait pattern), plus a start pulse during ACC -> same means as continuous case; extra start ignored; exactly one done pulse.
- rst pulsed asynchronously mid-ACC after 2 samples -> all outputs 0, ready=1 immediately; a fresh run of 4 samples of 5 gives xMean=5.
- dataValid with samples in IDLE before start, then 4 real samples -> pre-start samples excluded from result.
